// File: rtl/wb_arbiter_if.sv
// Register-file writeback bus: pipeline WB producer, MDU producer and the
// registered register-file write port plus hazard-unit status.
interface wb_arbiter_if #(
  parameter int AW = 2
);
  logic        p_we;
  logic [4:0]  p_wn;
  logic [31:0] p_d;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  m_wn;
  logic [31:0] m_d;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;
  logic        rf_src;
  logic [31:0] pend_mask;
  logic [AW:0] fifo_cnt;
  logic        stall_req;

  modport master (
    output p_we, p_wn, p_d, m_valid, m_wn, m_d,
    input  m_ready, rf_we, rf_wn, rf_d, rf_src, pend_mask, fifo_cnt, stall_req
  );

  modport slave (
    input  p_we, p_wn, p_d, m_valid, m_wn, m_d,
    output m_ready, rf_we, rf_wn, rf_d, rf_src, pend_mask, fifo_cnt, stall_req
  );
endinterface

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB always wins, MDU results are
// buffered in a small FIFO and drained in idle WB slots.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int AW           = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic         clk,
  input  logic         clrn,
  wb_arbiter_if.slave  bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);
  localparam logic [AW:0]   FULLC = (AW+1)'(DEPTH);

  logic [4:0]    fwn [DEPTH];
  logic [31:0]   fd  [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   cnt;
  logic [SW-1:0] starve, starve_nxt;
  logic          stall_q;
  logic          we_q, src_q;
  logic [4:0]    wn_q;
  logic [31:0]   d_q;
  logic          p_valid, empty, full, push, pop;
  logic [31:0]   mask;

  // Request qualification and arbitration decision
  always_comb begin
    p_valid = bus.p_we && (bus.p_wn != '0);
    empty   = (cnt == '0);
    full    = (cnt == FULLC);
    push    = bus.m_valid && !full && (bus.m_wn != '0);
    pop     = !p_valid && !empty;
    if (empty || pop)
      starve_nxt = '0;
    else if (starve == SLIM)
      starve_nxt = starve;
    else
      starve_nxt = starve + 1'b1;
  end

  // FIFO storage; contents need no reset since occupancy gates their use
  always_ff @(posedge clk) begin
    if (push) begin
      fwn[tail] <= bus.m_wn;
      fd[tail]  <= bus.m_d;
    end
  end

  // Pointers, occupancy, registered write port and starvation tracking
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      we_q    <= 1'b0;
      wn_q    <= '0;
      d_q     <= '0;
      src_q   <= 1'b0;
      starve  <= '0;
      stall_q <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (p_valid) begin
        we_q  <= 1'b1;
        wn_q  <= bus.p_wn;
        d_q   <= bus.p_d;
        src_q <= 1'b0;
      end else if (pop) begin
        we_q  <= 1'b1;
        wn_q  <= fwn[head];
        d_q   <= fd[head];
        src_q <= 1'b1;
      end else begin
        we_q  <= 1'b0;
      end
      starve  <= starve_nxt;
      stall_q <= (starve_nxt == SLIM);
    end
  end

  // Pending mask built only from registered FIFO and output-stage state
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((AW+1)'(i) < cnt)
        mask[fwn[head + AW'(i)]] = 1'b1;
    end
    if (we_q && src_q)
      mask[wn_q] = 1'b1;
    mask[0] = 1'b0;
  end

  assign bus.m_ready   = !full;
  assign bus.fifo_cnt  = cnt;
  assign bus.rf_we     = we_q;
  assign bus.rf_wn     = wn_q;
  assign bus.rf_d      = d_q;
  assign bus.rf_src    = src_q;
  assign bus.pend_mask = mask;
  assign bus.stall_req = stall_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter against a queue-based model.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIM   = 3;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  wb_arbiter_if #(.AW(2)) bus ();

  wb_arbiter #(.DEPTH(DEPTH), .AW(2), .STARVE_LIMIT(LIM)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  typedef struct { logic [4:0] wn; logic [31:0] d; } ent_t;
  typedef struct { logic [4:0] wn; logic [31:0] d; logic src; } wr_t;

  ent_t mq[$];
  wr_t  sb[$];
  logic        e_we, e_src;
  logic [4:0]  e_wn;
  logic [31:0] e_d;
  int          e_starve;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_pend();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].wn] = 1'b1;
    if (e_we && e_src) m[e_wn] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic model_reset();
    mq.delete();
    sb.delete();
    e_we = 1'b0; e_wn = '0; e_d = '0; e_src = 1'b0; e_starve = 0;
  endtask

  task automatic check_state();
    chk("fifo_cnt",  32'(bus.fifo_cnt), 32'(mq.size()));
    chk("m_ready",   32'(bus.m_ready), 32'(mq.size() < DEPTH));
    chk("pend_mask", bus.pend_mask, exp_pend());
    chk("stall_req", 32'(bus.stall_req), 32'(e_starve == LIM));
    chk("rf_we",     32'(bus.rf_we), 32'(e_we));
    chk("rf_wn",     32'(bus.rf_wn), 32'(e_wn));
    chk("rf_d",      bus.rf_d, e_d);
    chk("rf_src",    32'(bus.rf_src), 32'(e_src));
  endtask

  // Drive one cycle of inputs and advance the model by one clock edge
  task automatic step(input logic pwe, input logic [4:0] pwn, input logic [31:0] pd,
                      input logic mv, input logic [4:0] mwn, input logic [31:0] md);
    int   n;
    logic popped;
    ent_t e;
    bus.p_we = pwe; bus.p_wn = pwn; bus.p_d = pd;
    bus.m_valid = mv; bus.m_wn = mwn; bus.m_d = md;
    n = mq.size();
    popped = 1'b0;
    if (pwe && pwn != 5'd0) begin
      e_we = 1'b1; e_wn = pwn; e_d = pd; e_src = 1'b0;
      sb.push_back('{wn: pwn, d: pd, src: 1'b0});
    end else if (n > 0) begin
      e = mq.pop_front();
      popped = 1'b1;
      e_we = 1'b1; e_wn = e.wn; e_d = e.d; e_src = 1'b1;
      sb.push_back('{wn: e.wn, d: e.d, src: 1'b1});
    end else begin
      e_we = 1'b0;
    end
    if (mv && n < DEPTH && mwn != 5'd0)
      mq.push_back('{wn: mwn, d: md});
    if (n == 0 || popped) e_starve = 0;
    else if (e_starve < LIM) e_starve++;
  endtask

  task automatic cycle(input logic pwe, input logic [4:0] pwn, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mwn, input logic [31:0] md);
    @(negedge clk);
    check_state();
    step(pwe, pwn, pd, mv, mwn, md);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_state();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #2 clrn = 1'b0;
    model_reset();
    @(negedge clk);
    check_state();
    chk("reset_fifo_cnt", 32'(bus.fifo_cnt), 32'd0);
    chk("reset_m_ready",  32'(bus.m_ready), 32'd1);
    #1 clrn = 1'b1;
  endtask

  // Monitor: every registered write is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (clrn && bus.rf_we) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got write wn=%0d d=%h expected none at %0t",
                 bus.rf_wn, bus.rf_d, $time);
      end else begin
        wr_t w;
        w = sb.pop_front();
        chk("sb_wn",  32'(bus.rf_wn), 32'(w.wn));
        chk("sb_d",   bus.rf_d, w.d);
        chk("sb_src", 32'(bus.rf_src), 32'(w.src));
      end
    end
  end

  initial begin
    int phase_p;
    clrn = 1'b0;
    bus.p_we = 1'b0; bus.p_wn = '0; bus.p_d = '0;
    bus.m_valid = 1'b0; bus.m_wn = '0; bus.m_d = '0;
    model_reset();
    @(negedge clk);
    check_state();
    #1 clrn = 1'b1;

    // Pipeline only, then an r0 idle slot
    cycle(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, 5'd0, 32'h5555, 1'b0, 5'd0, 32'd0);
    idle(2);

    // MDU only
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hDEADBEEF);
    idle(4);

    // Fill under continuous pipeline traffic, fifth push held off
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 5'd1, 32'(i), 1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hB0B0_0000);
    idle(6);

    // Starvation of a single entry, then release
    cycle(1'b1, 5'd2, 32'd7, 1'b1, 5'd3, 32'hCAFE);
    for (int i = 0; i < 5; i++) cycle(1'b1, 5'd2, 32'(i), 1'b0, 5'd0, 32'd0);
    idle(3);

    // r0 result dropped
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hABCD);
    idle(2);

    // Reset with queued results
    cycle(1'b1, 5'd4, 32'd1, 1'b1, 5'd6, 32'h66);
    cycle(1'b1, 5'd4, 32'd2, 1'b1, 5'd7, 32'h77);
    do_reset();
    idle(2);

    // Randomized traffic with alternating pipeline pressure
    for (int i = 0; i < 3000; i++) begin
      phase_p = ((i / 150) % 2 == 0) ? 90 : 30;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cycle(($urandom_range(0, 99) < phase_p) ? 1'b1 : 1'b0,
              5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0,
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
              $urandom);
      end
    end

    idle(10);
    @(negedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
